sps_transmitter: RTL and testbench

Serial transmit end of the SPS interface; the counterpart of the receive-side sample/bit counters. Accepts one parallel data word with a load handshake and shifts out a FRAME_WIDTH-bit frame on a single line: start bit 0, DATA_WIDTH data bits LSB first, stop bit 1. Runs on the same 16x-data-rate clock as the receiver, holding each bit for OVERSAMPLE clocks. Exposes frame progress and an end-of-frame pulse in the same form the receiver does.

---
 rtl/sps_transmitter_pkg.sv | 30 +++
 rtl/sps_transmitter_tx_bit_timer.sv | 46 ++++
 rtl/sps_transmitter.sv | 152 +++++++++++++++
 tb/tb_sps_transmitter.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/sps_transmitter_pkg.sv
// -----------------------------------------------------------------------------
// sps_transmitter_pkg
// Shared SPS definitions used by both ends of the serial link.
//   - default frame geometry (frame width, payload width, oversample ratio)
//   - line levels for start bit, stop bit and idle (mark)
//   - FSM state encoding for the serial engines
//   - counter width helper for the oversample counters
// -----------------------------------------------------------------------------
package sps_transmitter_pkg;

  localparam int FRAME_WIDTH_DEF = 10;
  localparam int DATA_WIDTH_DEF  = 8;
  localparam int OVERSAMPLE_DEF  = 16;

  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } sps_state_e;

  // Width of a counter that spans 0..n-1; never narrower than one bit so a
  // degenerate OVERSAMPLE=1 still elaborates.
  function automatic int count_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sps_transmitter_tx_bit_timer.sv
// -----------------------------------------------------------------------------
// tx_bit_timer
// Oversample counter for the transmitter: counts 0..OVERSAMPLE-1 while
// enabled and flags the last clock of each bit period.
// Ports:
//   clk     in   rising-edge clock (16x data rate)
//   rst     in   asynchronous active-high reset
//   i_en    in   count enable (frame in flight)
//   i_clr   in   synchronous clear to 0 (has priority over i_en)
//   o_tick  out  high in the cycle where the count is OVERSAMPLE-1 and i_en=1
// -----------------------------------------------------------------------------
module tx_bit_timer
  import sps_transmitter_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  input  logic i_clr,
  output logic o_tick
);

  localparam int             CW        = count_width(OVERSAMPLE);
  localparam logic [CW-1:0]  COUNT_MAX = CW'(OVERSAMPLE - 1);

  logic [CW-1:0] r_count;
  logic          w_at_max;

  assign w_at_max = (r_count == COUNT_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      // Wrap explicitly so non-power-of-two ratios behave the same way.
      r_count <= w_at_max ? '0 : r_count + CW'(1);
    end
  end

  // Gated by the enable so an idle transmitter never reports a tick.
  assign o_tick = i_en & w_at_max;

endmodule

// File: rtl/sps_transmitter.sv
// -----------------------------------------------------------------------------
// sps_transmitter
// Serial transmit end of the SPS link. Accepts one word on load (when not
// busy) and shifts out start bit, DATA_WIDTH data bits LSB first, stop bit,
// each held for OVERSAMPLE clocks.
// Ports:
//   clk            in   16x data-rate clock, rising edge
//   rst            in   asynchronous active-high reset
//   data_in        in   word to send, sampled only on an accepted load
//   load           in   send request, accepted only while busy=0
//   tx             out  serial line, idles high
//   busy           out  frame in flight
//   bit_tick       out  one-cycle pulse on the last clock of each bit
//   frameProgress  out  index of the bit currently on tx, 0 when idle
//   endFrame       out  one-cycle pulse on the edge that completes a frame
// -----------------------------------------------------------------------------
module sps_transmitter
  import sps_transmitter_pkg::*;
#(
  parameter int FRAME_WIDTH = FRAME_WIDTH_DEF,
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int OVERSAMPLE  = OVERSAMPLE_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  load,
  output logic                  tx,
  output logic                  busy,
  output logic                  bit_tick,
  output logic [3:0]            frameProgress,
  output logic                  endFrame
);

  if (FRAME_WIDTH != DATA_WIDTH + 2) begin : g_bad_frame_width
    $error("sps_transmitter: FRAME_WIDTH must equal DATA_WIDTH+2");
  end
  if (FRAME_WIDTH > 15) begin : g_bad_frame_len
    $error("sps_transmitter: FRAME_WIDTH must fit a 4-bit bit index");
  end

  localparam logic [3:0] LAST_BIT = 4'(FRAME_WIDTH - 1);

  // Registered state
  sps_state_e             r_state;
  logic [FRAME_WIDTH-1:0] r_shift;
  logic                   r_tx;
  logic                   r_busy;
  logic [3:0]             r_progress;
  logic                   r_end;

  // Next-state values
  sps_state_e             w_state_next;
  logic [FRAME_WIDTH-1:0] w_shift_next;
  logic                   w_tx_next;
  logic                   w_busy_next;
  logic [3:0]             w_progress_next;
  logic                   w_end_next;

  // Timer control
  logic w_tmr_en;
  logic w_tmr_clr;
  logic w_tick;

  tx_bit_timer #(
    .OVERSAMPLE (OVERSAMPLE)
  ) u_bit_timer (
    .clk    (clk),
    .rst    (rst),
    .i_en   (w_tmr_en),
    .i_clr  (w_tmr_clr),
    .o_tick (w_tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_shift    <= '0;
      r_tx       <= IDLE_LEVEL;
      r_busy     <= 1'b0;
      r_progress <= 4'd0;
      r_end      <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_shift    <= w_shift_next;
      r_tx       <= w_tx_next;
      r_busy     <= w_busy_next;
      r_progress <= w_progress_next;
      r_end      <= w_end_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_shift_next    = r_shift;
    w_tx_next       = r_tx;
    w_busy_next     = r_busy;
    w_progress_next = r_progress;
    w_end_next      = 1'b0;
    w_tmr_en        = 1'b0;
    w_tmr_clr       = 1'b0;

    case (r_state)
      IDLE: begin
        // Hold the timer at zero so the first bit gets a full period.
        w_tmr_clr = 1'b1;
        if (load) begin
          w_state_next    = SEND;
          w_shift_next    = {STOP_BIT, data_in, START_BIT};
          w_tx_next       = START_BIT;
          w_busy_next     = 1'b1;
          w_progress_next = 4'd0;
        end
      end

      SEND: begin
        w_tmr_en = 1'b1;
        if (w_tick) begin
          if (r_progress == LAST_BIT) begin
            // Stop bit finished: back to mark. load is not looked at on this
            // edge, which is what guarantees the 1-clock idle gap.
            w_state_next    = IDLE;
            w_tx_next       = IDLE_LEVEL;
            w_busy_next     = 1'b0;
            w_progress_next = 4'd0;
            w_end_next      = 1'b1;
          end else begin
            // tx is registered, so it takes the bit that becomes the new LSB.
            w_shift_next    = {IDLE_LEVEL, r_shift[FRAME_WIDTH-1:1]};
            w_tx_next       = r_shift[1];
            w_progress_next = r_progress + 4'd1;
          end
        end
      end

      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // The register LSB is only the start bit, which r_tx already carries.
  logic w_unused;
  assign w_unused = r_shift[0];

  assign tx            = r_tx;
  assign busy          = r_busy;
  assign bit_tick      = w_tick;
  assign frameProgress = r_progress;
  assign endFrame      = r_end;

endmodule

// File: tb/tb_sps_transmitter.sv
// -----------------------------------------------------------------------------
// tb_sps_transmitter
// Directed bench for sps_transmitter with default geometry (10/8/16).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// Expected line patterns are written out by hand as 10-bit vectors where
// bit k is the level expected on tx during bit period k.
// -----------------------------------------------------------------------------
module tb_sps_transmitter;

  logic       clk = 1'b0;
  logic       rst;
  logic       load;
  logic [7:0] data_in;
  logic       tx;
  logic       busy;
  logic       bit_tick;
  logic [3:0] frameProgress;
  logic       endFrame;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  sps_transmitter #(
    .FRAME_WIDTH (10),
    .DATA_WIDTH  (8),
    .OVERSAMPLE  (16)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .data_in       (data_in),
    .load          (load),
    .tx            (tx),
    .busy          (busy),
    .bit_tick      (bit_tick),
    .frameProgress (frameProgress),
    .endFrame      (endFrame)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".tx"},       32'(tx), 32'd1);
    check({tag, ".busy"},     32'(busy), 32'd0);
    check({tag, ".progress"}, 32'(frameProgress), 32'd0);
    check({tag, ".endFrame"}, 32'(endFrame), 32'd0);
    check({tag, ".bit_tick"}, 32'(bit_tick), 32'd0);
  endtask

  // Present a word with load high; returns at the falling edge after E0.
  task automatic start(input logic [7:0] d);
    data_in = d;
    load    = 1'b1;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Called at the falling edge after E0. Checks every cycle of the frame and
  // the endFrame cycle; returns at the falling edge after E0+160.
  task automatic run_frame(input string name, input logic [9:0] line,
                           input bit keep_load, input int pulse_at,
                           input logic [7:0] next_data);
    int ticks = 0;
    int busy_cycles = 0;
    int k;
    for (int c = 0; c < 160; c++) begin
      k = c / 16;
      check($sformatf("%s.c%0d.tx", name, c),       32'(tx), 32'(line[k]));
      check($sformatf("%s.c%0d.busy", name, c),     32'(busy), 32'd1);
      check($sformatf("%s.c%0d.progress", name, c), 32'(frameProgress), 32'(k));
      check($sformatf("%s.c%0d.bit_tick", name, c), 32'(bit_tick), 32'((c % 16) == 15));
      check($sformatf("%s.c%0d.endFrame", name, c), 32'(endFrame), 32'd0);
      if (bit_tick === 1'b1) ticks++;
      if (busy === 1'b1) busy_cycles++;
      if (c == 0 && !keep_load) load = 1'b0;
      if (c == 1) data_in = next_data;
      if (pulse_at >= 0 && c == pulse_at) begin
        load    = 1'b1;
        data_in = 8'hFF;
      end
      if (pulse_at >= 0 && c == pulse_at + 1) load = 1'b0;
      @(negedge clk);
    end
    check({name, ".end.endFrame"}, 32'(endFrame), 32'd1);
    check({name, ".end.busy"},     32'(busy), 32'd0);
    check({name, ".end.tx"},       32'(tx), 32'd1);
    check({name, ".end.progress"}, 32'(frameProgress), 32'd0);
    check({name, ".end.bit_tick"}, 32'(bit_tick), 32'd0);
    check({name, ".ticks"},        32'(ticks), 32'd10);
    check({name, ".busy_cycles"},  32'(busy_cycles), 32'd160);
    $display("frame %s line=%b ticks=%0d busy_cycles=%0d", name, line, ticks, busy_cycles);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst     = 1'b1;
    load    = 1'b0;
    data_in = 8'h00;
    repeat (2) @(negedge clk);
    check_idle("reset");
    $display("reset state checked");
    rst = 1'b0;

    // Idle with load low
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      check_idle($sformatf("idle%0d", i));
    end
    $display("idle 50 clocks checked");

    // 0x55 -> 0,1,0,1,0,1,0,1,0,1
    start(8'h55);
    run_frame("x55", 10'b1010101010, 1'b0, -1, 8'h00);
    @(negedge clk);
    check_idle("x55.after");

    // 0xA3 -> data 1,1,0,0,0,1,0,1; data_in changes mid-frame
    start(8'hA3);
    run_frame("xA3", 10'b1101000110, 1'b0, -1, 8'h5A);
    @(negedge clk);
    check_idle("xA3.after");

    // 0x0F with an ignored load pulse of 0xFF 40 clocks in
    start(8'h0F);
    run_frame("x0F", 10'b1000011110, 1'b0, 40, 8'hF0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check_idle($sformatf("x0F.noqueue%0d", i));
    end

    // load held high: 0x01 then 0x80 back to back, 1-clock gap
    start(8'h01);
    run_frame("x01", 10'b1000000010, 1'b1, -1, 8'h80);
    @(negedge clk);
    run_frame("x80", 10'b1100000000, 1'b0, -1, 8'h00);
    @(negedge clk);
    check_idle("x80.after");

    // Reset in the middle of bit 4
    start(8'h55);
    load = 1'b0;
    repeat (74) @(negedge clk);
    check("rst.pre.tx",       32'(tx), 32'd0);
    check("rst.pre.progress", 32'(frameProgress), 32'd4);
    check("rst.pre.busy",     32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1 check_idle("rst.async");
    $display("mid-frame reset checked");
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      check_idle($sformatf("rst.idle%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
